// File: rtl/paralelo_serial.sv
// Byte-to-bit serializer, MSB first, one bit per clk; a byte taken at boundary edge E shows D[7] after E+1.
// No internal buffering: readyEntrada pulses once per byte; after reset N_COM 0xBC commas precede any data.
module paralelo_serial #(
   parameter int N_COM = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Entrada,
   input  logic       validEntrada,
   output logic       readyEntrada,
   output logic       Salida,
   output logic       activo
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [7:0] COMMA     = 8'hBC;
   localparam logic [3:0] LAST_COMA = 4'(N_COM - 1);

   logic [2:0] cnt_q, cnt_d;
   logic [7:0] actual_q, actual_d;
   logic [3:0] coma_cnt_q, coma_cnt_d;
   state_t     state_q, state_d;
   logic       salida_q, salida_d;
   logic       activo_q, activo_d;
   logic       boundary;

   always_comb begin
      boundary     = (cnt_q == 3'd7);
      readyEntrada = boundary && ((state_q == RUN) || (coma_cnt_q == LAST_COMA));

      cnt_d      = cnt_q + 3'd1;
      salida_d   = actual_q[3'd7 - cnt_q];
      actual_d   = actual_q;
      coma_cnt_d = coma_cnt_q;
      state_d    = state_q;
      activo_d   = activo_q;

      // Idle boundaries load a comma so the line never carries a gap.
      if (readyEntrada) begin
         actual_d = validEntrada ? Entrada : COMMA;
         if (state_q == INIT) begin
            state_d  = RUN;
            activo_d = 1'b1;
         end
      end else if (boundary) begin
         actual_d   = COMMA;
         coma_cnt_d = coma_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= 3'd0;
         actual_q   <= COMMA;
         coma_cnt_q <= 4'd0;
         state_q    <= INIT;
         salida_q   <= 1'b0;
         activo_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         actual_q   <= actual_d;
         coma_cnt_q <= coma_cnt_d;
         state_q    <= state_d;
         salida_q   <= salida_d;
         activo_q   <= activo_d;
      end
   end

   assign Salida = salida_q;
   assign activo = activo_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial (N_COM=4): comma preamble, data bytes, gaps, and resets.
// Outputs are sampled 1 time unit after each rising edge; sh collects the serial stream MSB first.
module tb_paralelo_serial;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] Entrada;
   logic       validEntrada;
   logic       readyEntrada;
   logic       Salida;
   logic       activo;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] sh = 8'h00;

   paralelo_serial #(.N_COM(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .Entrada      (Entrada),
      .validEntrada (validEntrada),
      .readyEntrada (readyEntrada),
      .Salida       (Salida),
      .activo       (activo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sh = {sh[6:0], Salida};
   endtask

   // Cycles 0..30 after reset release: three full commas plus seven bits of the fourth.
   task automatic init_seq(input logic vld, input logic [7:0] dat, input string tag);
      int rdy_early;
      rdy_early    = 0;
      validEntrada = vld;
      Entrada      = dat;
      for (int k = 0; k < 31; k++) begin
         if (readyEntrada) rdy_early++;
         tick();
         if (k == 0) chk({tag, "_first_bit"}, {7'd0, Salida}, 8'h01);
         if (k % 8 == 7) chk({tag, "_comma"}, sh, 8'hBC);
      end
      chk({tag, "_rdy_early"}, rdy_early[7:0], 8'h00);
      chk({tag, "_rdy_k31"}, {7'd0, readyEntrada}, 8'h01);
      chk({tag, "_activo_init"}, {7'd0, activo}, 8'h00);
      chk({tag, "_partial"}, {1'b0, sh[6:0]}, 8'h5E);
   endtask

   // Serializes the byte loaded at the previous boundary; presents the next one in the last cycle.
   task automatic run_byte(input logic [7:0] nxt, input logic nvld, input logic [7:0] exp,
                           input string tag);
      int rdy_mid;
      rdy_mid = 0;
      for (int b = 0; b < 8; b++) begin
         if (b == 7) begin
            chk({tag, "_rdy_bnd"}, {7'd0, readyEntrada}, 8'h01);
            Entrada      = nxt;
            validEntrada = nvld;
         end else if (readyEntrada) begin
            rdy_mid++;
         end
         tick();
      end
      chk({tag, "_byte"}, sh, exp);
      chk({tag, "_rdy_mid"}, rdy_mid[7:0], 8'h00);
      chk({tag, "_activo"}, {7'd0, activo}, 8'h01);
   endtask

   initial begin
      reset        = 1'b1;
      validEntrada = 1'b1;
      Entrada      = 8'h55;
      tick();
      tick();
      chk("rst_salida", {7'd0, Salida}, 8'h00);
      chk("rst_activo", {7'd0, activo}, 8'h00);
      chk("rst_ready", {7'd0, readyEntrada}, 8'h00);

      // 0x55 held valid through the preamble is first taken at k=31.
      #1 reset = 1'b0;
      init_seq(1'b1, 8'h55, "pre");
      tick();
      chk("pre_comma4", sh, 8'hBC);
      chk("pre_activo_k32", {7'd0, activo}, 8'h01);

      run_byte(8'hA5, 1'b1, 8'h55, "b55");
      run_byte(8'h01, 1'b1, 8'hA5, "bA5");
      run_byte(8'hFF, 1'b1, 8'h01, "b01");
      run_byte(8'h80, 1'b1, 8'hFF, "bFF");
      run_byte(8'h3C, 1'b1, 8'h80, "b80");
      run_byte(8'h00, 1'b0, 8'h3C, "b3C");
      run_byte(8'hC3, 1'b1, 8'hBC, "gap");
      run_byte(8'h00, 1'b0, 8'hC3, "bC3");
      run_byte(8'h00, 1'b0, 8'hBC, "idle");

      // Mid-byte reset while in RUN.
      tick();
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_salida", {7'd0, Salida}, 8'h00);
      chk("mid_rst_activo", {7'd0, activo}, 8'h00);
      chk("mid_rst_ready", {7'd0, readyEntrada}, 8'h00);
      reset = 1'b0;
      init_seq(1'b0, 8'h00, "re");

      // Reset coinciding with an acceptance discards the byte and restarts the preamble.
      Entrada      = 8'hAA;
      validEntrada = 1'b1;
      reset        = 1'b1;
      tick();
      chk("bnd_rst_activo", {7'd0, activo}, 8'h00);
      chk("bnd_rst_salida", {7'd0, Salida}, 8'h00);
      reset        = 1'b0;
      validEntrada = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("bnd_rst_comma", sh, 8'hBC);
      chk("bnd_rst_activo_after", {7'd0, activo}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
